io_bus_master: RTL and testbench

- Initiator for the 8-bit peripheral register bus (sel/read/write/addr/data) that the USB FIFO interface responds on.
- Accepts one 32-bit CPU load/store request at a time and splits it into 1, 2 or 4 byte beats on the peripheral bus.
- Assembles read bytes little-endian into a 32-bit result and returns one response pulse per request.
- Sits between the CPU datapath and the peripheral responder(s) inside the application module.

---
 rtl/io_bus_pkg.sv | 25 ++
 rtl/io_bus_rd_pack.sv | 78 +++++++
 rtl/io_bus_master.sv | 197 +++++++++++++++++++
 tb/tb_io_bus_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared types and helpers for the 8-bit peripheral bus initiator.
// Optional sign extension of loads is enabled by defining IO_BUS_SIGNEXT_EN.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT_RD,
        RESP
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Number of byte beats for a request size; size 3 is treated as a word.
    function automatic logic [2:0] beats_for_size(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/io_bus_rd_pack.sv
// Load result assembly: byte-lane insert per beat, final zero/sign extension
// and the registered response data.
// Sign extension logic exists only when IO_BUS_SIGNEXT_EN is defined.
module io_bus_rd_pack import io_bus_pkg::*; (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        clear_i,
    input  logic        sample_i,
    input  logic [1:0]  beat_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  size_i,
`ifdef IO_BUS_SIGNEXT_EN
    input  logic        sign_i,
`endif
    input  logic        store_i,
    input  logic        load_i,
    output logic [31:0] rdata_o
);

    logic [31:0] res_q, res_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ext;
    logic        fill;

    // Result register: cleared on acceptance, one byte lane written per read beat.
    always_comb begin
        res_d = res_q;
        if (clear_i) begin
            res_d = '0;
        end else if (sample_i) begin
            res_d[{beat_i, 3'b000} +: 8] = byte_i;
        end
    end

    // Extension works on the next-state result so the final sample and the
    // response register update on the same edge.
    always_comb begin
        fill = 1'b0;
        ext  = res_d;
        case (size_i)
            SZ_BYTE: begin
`ifdef IO_BUS_SIGNEXT_EN
                fill = sign_i & res_d[7];
`endif
                ext = {{24{fill}}, res_d[7:0]};
            end
            SZ_HALF: begin
`ifdef IO_BUS_SIGNEXT_EN
                fill = sign_i & res_d[15];
`endif
                ext = {{16{fill}}, res_d[15:0]};
            end
            default: ext = res_d;
        endcase
    end

    // Response data only changes when a response is issued; stores return zero.
    always_comb begin
        rdata_d = rdata_q;
        if (load_i) begin
            rdata_d = store_i ? 32'd0 : ext;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            res_q   <= '0;
            rdata_q <= '0;
        end else begin
            res_q   <= res_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/io_bus_master.sv
// Peripheral bus initiator: splits one 32-bit CPU load/store into 1/2/4 byte
// beats at a fixed FIFO address and returns one response pulse per request.
// Define IO_BUS_SIGNEXT_EN to honour req_signed_i on sub-word loads.
module io_bus_master import io_bus_pkg::*; #(
    parameter int ADDR_W     = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              bus_sel_o,
    output logic              bus_read_o,
    output logic              bus_write_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [7:0]        bus_data_o,
    input  logic [7:0]        bus_data_i
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        data_q, data_d;
    logic              sel_q, sel_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              rsp_q, rsp_d;
    logic              clear, sample;
    logic [1:0]        last_beat, beat_inc;

`ifdef IO_BUS_SIGNEXT_EN
    logic              sgn_q, sgn_d;
`else
    logic              unused_signed;
    assign unused_signed = req_signed_i;
`endif

    assign last_beat = 2'(beats_for_size(size_q) - 3'd1);
    assign beat_inc  = beat_q + 2'd1;

    // Next-state and registered-output decode; strobes are set on the edge
    // that enters ACCESS so they appear during the ACCESS cycle.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wcnt_d  = wcnt_q;
        size_d  = size_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = 1'b0;
        read_d  = 1'b0;
        write_d = 1'b0;
        clear   = 1'b0;
        sample  = 1'b0;
`ifdef IO_BUS_SIGNEXT_EN
        sgn_d   = sgn_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    wdata_d = req_wdata_i;
                    beat_d  = 2'd0;
                    clear   = 1'b1;
`ifdef IO_BUS_SIGNEXT_EN
                    sgn_d   = req_signed_i;
`endif
                    state_d = ACCESS;
                    sel_d   = 1'b1;
                    read_d  = ~req_we_i;
                    write_d = req_we_i;
                    addr_d  = req_addr_i;
                    if (req_we_i) begin
                        data_d = req_wdata_i[7:0];
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    if (beat_q == last_beat) begin
                        state_d = RESP;
                    end else begin
                        beat_d  = beat_inc;
                        sel_d   = 1'b1;
                        write_d = 1'b1;
                        data_d  = wdata_q[{beat_inc, 3'b000} +: 8];
                    end
                end else begin
                    wcnt_d  = 2'd0;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                wcnt_d = wcnt_q + 2'd1;
                if (wcnt_q == WAIT_LAST) begin
                    sample = 1'b1;
                    if (beat_q == last_beat) begin
                        state_d = RESP;
                    end else begin
                        beat_d  = beat_inc;
                        state_d = ACCESS;
                        sel_d   = 1'b1;
                        read_d  = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rsp_d = (state_d == RESP);
    end

    // Control and bus output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wcnt_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            rsp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
            size_q  <= size_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            read_q  <= read_d;
            write_q <= write_d;
            rsp_q   <= rsp_d;
        end
    end

`ifdef IO_BUS_SIGNEXT_EN
    // Signed-load flag, only kept when sign extension is built in.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sgn_q <= 1'b0;
        end else begin
            sgn_q <= sgn_d;
        end
    end
`endif

    io_bus_rd_pack u_rd_pack (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clear_i  (clear),
        .sample_i (sample),
        .beat_i   (beat_q),
        .byte_i   (bus_data_i),
        .size_i   (size_q),
`ifdef IO_BUS_SIGNEXT_EN
        .sign_i   (sgn_q),
`endif
        .store_i  (we_q),
        .load_i   (rsp_d),
        .rdata_o  (rsp_rdata_o)
    );

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_q;
    assign bus_sel_o   = sel_q;
    assign bus_read_o  = read_q;
    assign bus_write_o = write_q;
    assign bus_addr_o  = addr_q;
    assign bus_data_o  = data_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: instance 0 uses RD_LATENCY=1, instance 1
// uses RD_LATENCY=3; a delay-line responder supplies read bytes.
module tb_io_bus_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rv0, rv1;
    logic        we, sgn;
    logic [1:0]  size, addr;
    logic [31:0] wdata;

    logic        rdy0, rdy1, rspv0, rspv1;
    logic [31:0] rdat0, rdat1;
    logic        sel0, sel1, rd0, rd1, wr0, wr1;
    logic [1:0]  ba0, ba1;
    logic [7:0]  do0, do1;
    logic [7:0]  p0;
    logic [7:0]  p1 [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cur    = 0;
    int viol   = 0;
    int T;

    logic [7:0] bq [$];
    int         rd_t [$];
    int         wr_t [$];
    logic [7:0] wr_d [$];
    logic [1:0] wr_a [$];
    int         rsp_t [$];
    logic [31:0] rsp_d [$];
    int         acc_t [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    io_bus_master #(.ADDR_W(2), .RD_LATENCY(1)) dut (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(rv0), .req_ready_o(rdy0),
        .req_we_i(we), .req_size_i(size), .req_signed_i(sgn), .req_addr_i(addr),
        .req_wdata_i(wdata), .rsp_valid_o(rspv0), .rsp_rdata_o(rdat0),
        .bus_sel_o(sel0), .bus_read_o(rd0), .bus_write_o(wr0), .bus_addr_o(ba0),
        .bus_data_o(do0), .bus_data_i(p0)
    );

    io_bus_master #(.ADDR_W(2), .RD_LATENCY(3)) dut3 (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(rv1), .req_ready_o(rdy1),
        .req_we_i(we), .req_size_i(size), .req_signed_i(sgn), .req_addr_i(addr),
        .req_wdata_i(wdata), .rsp_valid_o(rspv1), .rsp_rdata_o(rdat1),
        .bus_sel_o(sel1), .bus_read_o(rd1), .bus_write_o(wr1), .bus_addr_o(ba1),
        .bus_data_o(do1), .bus_data_i(p1[2])
    );

    // Responder: read byte valid exactly RD_LATENCY cycles after the strobe, zero otherwise.
    always @(posedge clk) begin
        if (rd0 && bq.size() > 0) p0 <= bq.pop_front();
        else p0 <= 8'h00;
        if (rd1 && bq.size() > 0) p1[0] <= bq.pop_front();
        else p1[0] <= 8'h00;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end

    logic       m_rd, m_wr, m_sel, m_rsp, m_rv, m_rdy;
    logic [7:0] m_do;
    logic [1:0] m_a;
    logic [31:0] m_rdat;
    assign m_rd   = cur ? rd1   : rd0;
    assign m_wr   = cur ? wr1   : wr0;
    assign m_sel  = cur ? sel1  : sel0;
    assign m_rsp  = cur ? rspv1 : rspv0;
    assign m_rv   = cur ? rv1   : rv0;
    assign m_rdy  = cur ? rdy1  : rdy0;
    assign m_do   = cur ? do1   : do0;
    assign m_a    = cur ? ba1   : ba0;
    assign m_rdat = cur ? rdat1 : rdat0;

    // Event log of the instance under test, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstn) begin
            if (m_rd) rd_t.push_back(cyc);
            if (m_wr) begin
                wr_t.push_back(cyc);
                wr_d.push_back(m_do);
                wr_a.push_back(m_a);
            end
            if (m_rsp) begin
                rsp_t.push_back(cyc);
                rsp_d.push_back(m_rdat);
            end
            if (m_rv && m_rdy) acc_t.push_back(cyc);
            if ((m_rd && m_wr) || (m_sel != (m_rd | m_wr))) viol++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rd_t.delete(); wr_t.delete(); wr_d.delete(); wr_a.delete();
        rsp_t.delete(); rsp_d.delete(); acc_t.delete();
    endtask

    task automatic issue(input int inst, input logic w, input logic [1:0] sz,
                         input logic s, input logic [1:0] a, input logic [31:0] d);
        clr();
        cur = inst;
        we = w; size = sz; sgn = s; addr = a; wdata = d;
        if (inst == 0) rv0 = 1'b1; else rv1 = 1'b1;
        step();
        rv0 = 1'b0; rv1 = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 200 && rsp_t.size() < n; i++) step();
        repeat (3) step();
        chk("rsp_count", rsp_t.size(), n);
        T = (acc_t.size() > 0) ? acc_t[0] : -1000;
    endtask

    initial begin
        logic [7:0] sb [4];
        rstn = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
        we = 1'b0; sgn = 1'b0; size = 2'd0; addr = 2'd0; wdata = 32'd0;
        step(); step();
        chk("rst_ready0", rdy0, 1);
        chk("rst_ready1", rdy1, 1);
        chk("rst_sel", sel0, 0);
        chk("rst_rd", rd0, 0);
        chk("rst_wr", wr0, 0);
        chk("rst_addr", ba0, 0);
        chk("rst_data", do0, 0);
        chk("rst_rspv", rspv0, 0);
        chk("rst_rdata", rdat0, 0);
        rstn = 1'b1;
        step();

        // Word store: bytes D4,C3,B2,A1 back-to-back at fixed address 1.
        issue(0, 1'b1, 2'd2, 1'b0, 2'b01, 32'hA1B2C3D4);
        wait_rsp(1);
        sb[0] = 8'hD4; sb[1] = 8'hC3; sb[2] = 8'hB2; sb[3] = 8'hA1;
        chk("st_nwr", wr_t.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("st_time", wr_t[k], T + 1 + k);
            chk("st_byte", wr_d[k], sb[k]);
            chk("st_addr", wr_a[k], 2'b01);
        end
        chk("st_nrd", rd_t.size(), 0);
        chk("st_rsp_t", rsp_t[0], T + 5);
        chk("st_rdata", rsp_d[0], 32'h0);

        // Word load, latency 1.
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        issue(0, 1'b0, 2'd2, 1'b0, 2'b01, 32'h0);
        wait_rsp(1);
        chk("ld_nrd", rd_t.size(), 4);
        for (int k = 0; k < 4; k++) chk("ld_time", rd_t[k], T + 1 + 2 * k);
        chk("ld_rsp_t", rsp_t[0], T + 9);
        chk("ld_rdata", rsp_d[0], 32'h44332211);
        chk("ld_nwr", wr_t.size(), 0);

        // Signed byte load of 0x80.
        bq = '{8'h80};
        issue(0, 1'b0, 2'd0, 1'b1, 2'b00, 32'h0);
        wait_rsp(1);
        chk("sb_rsp_t", rsp_t[0], T + 3);
`ifdef IO_BUS_SIGNEXT_EN
        chk("sb_rdata", rsp_d[0], 32'hFFFFFF80);
`else
        chk("sb_rdata", rsp_d[0], 32'h00000080);
`endif

        // Unsigned byte load of 0x80.
        bq = '{8'h80};
        issue(0, 1'b0, 2'd0, 1'b0, 2'b00, 32'h0);
        wait_rsp(1);
        chk("ub_rdata", rsp_d[0], 32'h00000080);

        // Signed half load of 0x7F,0x80.
        bq = '{8'h7F, 8'h80};
        issue(0, 1'b0, 2'd1, 1'b1, 2'b11, 32'h0);
        wait_rsp(1);
        chk("sh_nrd", rd_t.size(), 2);
        chk("sh_rsp_t", rsp_t[0], T + 5);
`ifdef IO_BUS_SIGNEXT_EN
        chk("sh_rdata", rsp_d[0], 32'hFFFF807F);
`else
        chk("sh_rdata", rsp_d[0], 32'h0000807F);
`endif

        // Size 3 behaves as a word, never extended.
        bq = '{8'h01, 8'h02, 8'h03, 8'h84};
        issue(0, 1'b0, 2'd3, 1'b1, 2'b00, 32'h0);
        wait_rsp(1);
        chk("s3_nrd", rd_t.size(), 4);
        chk("s3_rdata", rsp_d[0], 32'h84030201);

        // Latency 3 half load.
        bq = '{8'h34, 8'h12};
        issue(1, 1'b0, 2'd1, 1'b0, 2'b10, 32'h0);
        wait_rsp(1);
        chk("l3_nrd", rd_t.size(), 2);
        chk("l3_t0", rd_t[0], T + 1);
        chk("l3_t1", rd_t[1], T + 5);
        chk("l3_rsp_t", rsp_t[0], T + 9);
        chk("l3_rdata", rsp_d[0], 32'h00001234);

        // Back-to-back half stores with valid held high.
        clr();
        cur = 0; we = 1'b1; size = 2'd1; sgn = 1'b0; addr = 2'b00; wdata = 32'h0000BEEF;
        rv0 = 1'b1;
        for (int i = 0; i < 40 && acc_t.size() < 2; i++) step();
        rv0 = 1'b0;
        chk("b2b_nacc", acc_t.size(), 2);
        wait_rsp(2);
        chk("b2b_gap", acc_t[1] - acc_t[0], 4);
        chk("b2b_nwr", wr_t.size(), 4);
        chk("b2b_rsp0", rsp_t[0], acc_t[0] + 3);
        chk("b2b_rsp1", rsp_t[1], acc_t[1] + 3);
        chk("b2b_d2", wr_d[2], 8'hEF);
        chk("b2b_d3", wr_d[3], 8'hBE);

        // Reset after the second read strobe of a word load.
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        issue(0, 1'b0, 2'd2, 1'b0, 2'b10, 32'h0);
        for (int i = 0; i < 20 && rd_t.size() < 2; i++) step();
        chk("mr_nrd", rd_t.size(), 2);
        chk("mr_busy", rdy0, 0);
        rstn = 1'b0;
        #1;
        chk("mr_ready", rdy0, 1);
        chk("mr_sel", sel0, 0);
        chk("mr_rd", rd0, 0);
        chk("mr_addr", ba0, 0);
        chk("mr_data", do0, 0);
        chk("mr_rspv", rspv0, 0);
        step(); step(); step();
        rstn = 1'b1;
        bq.delete();
        repeat (8) step();
        chk("mr_norsp", rsp_t.size(), 0);

        // Next request after reset completes normally.
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        issue(0, 1'b0, 2'd2, 1'b0, 2'b01, 32'h0);
        wait_rsp(1);
        chk("pr_rsp_t", rsp_t[0], T + 9);
        chk("pr_rdata", rsp_d[0], 32'hDDCCBBAA);

        chk("strobe_viol", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
